round_key_scheduler: RTL

Sequencing controller for the AES-128 key expansion engine. It accepts a 128-bit cipher key, drives the engine through rounds 1..10 (one `enable` pulse per round), and stores the 11 round keys in an internal 11x128 register file. It also serves the cipher datapath's round-key reads through a request/acknowledge port. Reads of keys not yet generated stall until the key exists. A watchdog flags an engine that never completes.

---
 rtl/round_key_scheduler_if.sv | 34 +++
 rtl/round_key_scheduler.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/round_key_scheduler_if.sv
// Signal bundle around the round-key scheduler: key load, expansion-engine handshake
// and round-key read port. The scheduler is the slave; the surrounding datapath is the master.
interface round_key_scheduler_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;

    logic         exp_enable;
    logic [3:0]   exp_round;
    logic [127:0] exp_old_key;
    logic [127:0] exp_new_key;
    logic         exp_done;

    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_ack;
    logic [127:0] rk_data;

    logic         keys_ready;
    logic         busy;
    logic         err;

    modport slave (
        input  key_valid, key_in, exp_new_key, exp_done, rk_req, rk_idx,
        output key_ready, exp_enable, exp_round, exp_old_key, rk_ack, rk_data,
               keys_ready, busy, err
    );

    modport master (
        output key_valid, key_in, exp_new_key, exp_done, rk_req, rk_idx,
        input  key_ready, exp_enable, exp_round, exp_old_key, rk_ack, rk_data,
               keys_ready, busy, err
    );
endinterface

// File: rtl/round_key_scheduler.sv
// AES-128 round-key sequencer: drives the expansion engine through rounds 1..10,
// stores all 11 round keys and serves read requests that stall until a key exists.
module round_key_scheduler #(
    parameter int TIMEOUT = 64  // WAIT cycles tolerated before the engine is declared dead, 2..255
) (
    input logic                  clk,
    input logic                  n_rst,
    round_key_scheduler_if.slave bus
);

    localparam int         NUM_KEYS   = 11;
    localparam logic [3:0] LAST_ROUND = 4'd10;
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] slot [NUM_KEYS];
    logic [10:0]  valid;
    logic [3:0]   rnd;
    logic [7:0]   wd;

    logic         accept;
    logic         load_key;
    logic         store_key;
    logic         next_round;

    logic [15:0]  valid_ext;
    logic         idx_oob;
    logic         rd_hit;
    logic [127:0] rd_data;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        store_key       = 1'b0;
        next_round      = 1'b0;
        bus.exp_enable  = 1'b0;
        bus.exp_round   = '0;
        bus.exp_old_key = '0;
        bus.busy        = 1'b0;
        bus.keys_ready  = 1'b0;
        bus.err         = 1'b0;

        case (state)
            IDLE: begin
                accept = 1'b1;
            end
            START: begin
                bus.exp_enable  = 1'b1;
                bus.exp_round   = rnd;
                bus.exp_old_key = slot[rnd - 4'd1];
                bus.busy        = 1'b1;
                state_nxt       = WAIT;
            end
            WAIT: begin
                bus.exp_round   = rnd;
                bus.exp_old_key = slot[rnd - 4'd1];
                bus.busy        = 1'b1;
                // A result arriving on the last watchdog cycle still counts.
                if (bus.exp_done) begin
                    store_key = 1'b1;
                    if (rnd == LAST_ROUND) begin
                        state_nxt = DONE;
                    end else begin
                        next_round = 1'b1;
                        state_nxt  = START;
                    end
                end else if (wd == WD_LAST) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                accept         = 1'b1;
                bus.keys_ready = 1'b1;
            end
            ERR: begin
                accept  = 1'b1;
                bus.err = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        bus.key_ready = accept;
        load_key      = accept && bus.key_valid;
        if (load_key) begin
            state_nxt = START;
        end
    end

    // NOTE: the key file is reset so reads after reset can never return stale key material.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                slot[i] <= '0;
            end
            valid <= '0;
            rnd   <= '0;
            wd    <= '0;
        end else begin
            // A new key invalidates rounds 1..10 but leaves their old contents in place.
            if (load_key) begin
                slot[0] <= bus.key_in;
                valid   <= 11'b1;
                rnd     <= 4'd1;
            end
            if (store_key) begin
                slot[rnd]  <= bus.exp_new_key;
                valid[rnd] <= 1'b1;
            end
            if (next_round) begin
                rnd <= rnd + 4'd1;
            end
            if (state == START) begin
                wd <= '0;
            end else if (state == WAIT) begin
                wd <= wd + 8'd1;
            end
        end
    end

    // Read port: a held request is re-evaluated every cycle against pre-edge slot/valid.
    assign valid_ext = {5'b0, valid};
    assign idx_oob   = bus.rk_idx > LAST_ROUND;
    assign rd_hit    = bus.rk_req && !bus.rk_ack && (idx_oob || valid_ext[bus.rk_idx]);

    always_comb begin
        rd_data = '0;
        if (!idx_oob) begin
            rd_data = slot[bus.rk_idx];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.rk_ack  <= 1'b0;
            bus.rk_data <= '0;
        end else begin
            bus.rk_ack  <= rd_hit;
            bus.rk_data <= rd_hit ? rd_data : '0;
        end
    end

endmodule
